// File: rtl/imm_ext_stage.sv
// Immediate-extension pipeline stage: decodes the MIPS opcode, extends/shifts the immediate, buffers via skid or single register.
// Optional macro IMM_EXT_ILLEGAL_EN adds a buffered illegal-opcode flag; undefined ties out_illegal to 0.
module imm_ext_stage #(
   parameter int DATA_W  = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_pc4,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic [2:0]        out_mode,
   output logic              out_illegal
);

   localparam logic [2:0] MODE_SIGN   = 3'd0;
   localparam logic [2:0] MODE_ZERO   = 3'd1;
   localparam logic [2:0] MODE_LUI    = 3'd2;
   localparam logic [2:0] MODE_BRANCH = 3'd3;
   localparam logic [2:0] MODE_JUMP   = 3'd4;

   logic [5:0]        opcode;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] new_imm;
   logic [2:0]        new_mode;
   logic              new_ill;

   assign opcode = in_instr[31:26];
   assign imm16  = in_instr[15:0];

   always_comb begin
      new_imm  = DATA_W'(imm16);
      new_mode = MODE_ZERO;
      new_ill  = 1'b0;
      case (opcode)
         6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b100011, 6'b101011: begin
            new_imm  = DATA_W'($signed(imm16));
            new_mode = MODE_SIGN;
         end
         6'b001100, 6'b001101, 6'b001110: begin
            new_imm  = DATA_W'(imm16);
            new_mode = MODE_ZERO;
         end
         6'b001111: begin
            new_imm  = DATA_W'($signed({imm16, 16'h0000}));
            new_mode = MODE_LUI;
         end
         6'b000100, 6'b000101: begin
            new_imm  = DATA_W'($signed({imm16, 2'b00}));
            new_mode = MODE_BRANCH;
         end
         6'b000010, 6'b000011: begin
            new_imm  = {in_pc4[DATA_W-1:28], in_instr[25:0], 2'b00};
            new_mode = MODE_JUMP;
         end
         default: begin
            new_imm  = DATA_W'(imm16);
            new_mode = MODE_ZERO;
            new_ill  = 1'b1;
         end
      endcase
   end

   // Jump targets keep only the PC region bits; the low PC bits are replaced by the index.
   logic unused_pc_lo;
   assign unused_pc_lo = ^in_pc4[27:0];

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_imm_q,   out_imm_d;
   logic [2:0]        out_mode_q,  out_mode_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_imm_q,   skid_imm_d;
   logic [2:0]        skid_mode_q,  skid_mode_d;
`ifdef IMM_EXT_ILLEGAL_EN
   logic              out_ill_q,  out_ill_d;
   logic              skid_ill_q, skid_ill_d;
`else
   logic              unused_ill;
   assign unused_ill = new_ill;
`endif

   logic in_xfer;
   logic out_xfer;

   assign in_ready = SKID_EN ? !skid_valid_q : (!out_valid_q || out_ready);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_mode_d   = out_mode_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_mode_d  = skid_mode_q;
`ifdef IMM_EXT_ILLEGAL_EN
      out_ill_d    = out_ill_q;
      skid_ill_d   = skid_ill_q;
`endif
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_xfer) begin
         // A full skid always has priority so ordering is preserved; in_ready is low then.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_mode_d   = skid_mode_q;
            skid_valid_d = 1'b0;
`ifdef IMM_EXT_ILLEGAL_EN
            out_ill_d    = skid_ill_q;
`endif
         end else if (in_xfer) begin
            out_valid_d  = 1'b1;
            out_imm_d    = new_imm;
            out_mode_d   = new_mode;
`ifdef IMM_EXT_ILLEGAL_EN
            out_ill_d    = new_ill;
`endif
         end else begin
            out_valid_d  = 1'b0;
         end
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = new_imm;
         skid_mode_d  = new_mode;
`ifdef IMM_EXT_ILLEGAL_EN
         skid_ill_d   = new_ill;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_mode_q   <= 3'd0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_mode_q  <= 3'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_mode_q   <= out_mode_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_mode_q  <= skid_mode_d;
      end
   end

`ifdef IMM_EXT_ILLEGAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ill_q  <= 1'b0;
         skid_ill_q <= 1'b0;
      end else begin
         out_ill_q  <= out_ill_d;
         skid_ill_q <= skid_ill_d;
      end
   end
   assign out_illegal = out_ill_q;
`else
   assign out_illegal = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_imm   = out_imm_q;
   assign out_mode  = out_mode_q;

endmodule
